hamming_result_fifo: RTL and testbench
======================================

Name: hamming_result_fifo

Overview:
- Stage directly downstream of the SECDED decoder. Captures each decoded nibble together with its single/double error flags through a valid/ready handshake.
- Buffers results in a small FIFO that is drained by the display/UART consumer.
- Keeps saturating statistics counters: clean, corrected and uncorrectable words.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2.
- CNT_W, 8: width of each statistics counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decoder result present this cycle.
- in_ready  out  1  stage can accept a result.
- in_data  in  4  corrected data d3..d0 from decoder.
- in_single  in  1  decoder single_error flag.
- in_double  in  1  decoder double_error flag.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  consumer takes head entry.
- out_data  out  4  head entry data.
- out_status  out  2  head entry status: 00 clean, 01 corrected, 10 uncorrectable.
- clear_counts  in  1  synchronous clear of the three counters.
- ok_count  out  CNT_W  clean words accepted.
- corr_count  out  CNT_W  single-error (corrected) words accepted.
- uncorr_count  out  CNT_W  double-error words accepted.
- fifo_level  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Occupancy, read pointer and write pointer go to 0.
  - out_valid=0, out_data=0, out_status=00, fifo_level=0.
  - All counters go to 0; in_ready=1 in the cycle after reset.
  - Reset mid-transfer discards all buffered entries. No partial state survives.
- Handshakes:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (fifo_level != DEPTH), combinational from registered state only. There is no out_ready→in_ready path.
  - out_valid = (fifo_level != 0).
- Status encoding on push:
  - in_double=1 → 10, regardless of in_single. Double wins.
  - else in_single=1 → 01.
  - else → 00.
  - 11 is never produced.
- Data storage: in_data is stored unchanged, even for uncorrectable words.
- Latency:
  - A result pushed at edge k is visible on out_data/out_status with out_valid=1 after edge k, when the FIFO was empty. One cycle, no combinational bypass.
  - out_data/out_status always reflect the head entry. Their value when out_valid=0 is don't-care, but they must not be X after reset.
- Occupancy:
  - Push only → level+1. Pop only → level−1. Push and pop together → level unchanged, and both pointers advance.
  - Push is impossible when full. Pop is impossible when empty.
  - Pointers wrap modulo DEPTH.
  - Ordering is strictly FIFO.
- Counters:
  - On push, exactly one counter increments, selected by the status above.
  - Each counter saturates at 2^CNT_W−1 and does not wrap.
  - clear_counts=1 sets all counters to 0 at the edge. If a push occurs in the same cycle, clear wins and that word is not counted; the word is still stored in the FIFO.
  - clear_counts has no effect on FIFO contents.
- in_valid may be held high continuously; one word is accepted per cycle while in_ready=1.

Test Plan:
- Reset, then push in_data=4'hA with flags 0/0 → next cycle out_valid=1, out_data=A, out_status=00, ok_count=1, fifo_level=1. Pop → out_valid=0, fifo_level=0.
- With out_ready=0, push 5 words (3,5,7,9,B) with in_valid held high → first 4 accepted, in_ready=0, fifo_level=4. Drain → order 3,5,7,9. Word B is accepted only after the first pop.
- Push in_single=1,in_double=1,data=6 → out_status=10, uncorr_count=1, corr_count=0. Push in_single=1,data=2 → out_status=01, corr_count=1.
- CNT_W=2: push 5 clean words → ok_count sticks at 3. Assert clear_counts together with a single-error push → all counters 0, but the entry is still present with status 01.
- With the FIFO at level 2, push and pop simultaneously for 6 cycles → fifo_level stays 2, pointer wrap-around is exercised, and output order is preserved.
- With the FIFO at level 3 and counters non-zero, pulse rst_n low for one cycle → out_valid=0, fifo_level=0, all counters 0, in_ready=1 in the following cycle.

Source files
------------

// File: rtl/hamming_result_fifo.sv
// Result buffer behind the SECDED decoder: captures decoded nibbles plus a
// 2-bit status through valid/ready, holds them in a small FIFO for the
// display/UART consumer, and keeps saturating clean/corrected/uncorrectable
// word counters.
module hamming_result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_single,
  input  logic             in_double,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [1:0]       out_status,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count,
  output logic [LVL_W-1:0] fifo_level
);

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Storage: data and status kept side by side per entry.
  logic [3:0]       data_mem_q [DEPTH];
  logic [1:0]       stat_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic             push;
  logic             pop;
  logic [1:0]       push_status;

  // Handshake flags depend on registered occupancy only, so a stalled
  // consumer never creates a combinational path back to the decoder.
  assign in_ready  = (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // A double error dominates; 2'b11 can never be produced.
  assign push_status = in_double ? 2'b10 : (in_single ? 2'b01 : 2'b00);

  // Head of queue is always presented; storage is reset so it is never X.
  assign out_data     = data_mem_q[rd_ptr_q];
  assign out_status   = stat_mem_q[rd_ptr_q];
  assign fifo_level   = level_q;
  assign ok_count     = cnt_q[0];
  assign corr_count   = cnt_q[1];
  assign uncorr_count = cnt_q[2];

  // Next-state for pointers and occupancy; pointers wrap naturally because
  // DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each entry captures the incoming word when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_mem_q[gi] <= '0;
          stat_mem_q[gi] <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          data_mem_q[gi] <= in_data;
          stat_mem_q[gi] <= push_status;
        end
      end
    end

    // Counter index matches the status code: 0 clean, 1 corrected, 2 uncorrectable.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      // Saturating increment when a word of this class is accepted; clear wins.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (clear_counts) begin
          cnt_d[gi] = '0;
        end else if (push && (push_status == 2'(gi)) && (cnt_q[gi] != CNT_MAX)) begin
          cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
        end
      end

      // Counter register.
      always_ff @(posedge clk) begin
        if (!rst_n) cnt_q[gi] <= '0;
        else        cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

endmodule

// File: tb/tb_hamming_result_fifo.sv
// Self-checking bench for hamming_result_fifo: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_hamming_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = '0;
  logic             in_single = 1'b0;
  logic             in_double = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_data;
  logic [1:0]       out_status;
  logic             clear_counts = 1'b0;
  logic [CNT_W-1:0] ok_count;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;
  logic [LVL_W-1:0] fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of {data, status} words and three plain counters.
  logic [5:0] mq[$];
  int         mcnt[3];

  always #5 clk = ~clk;

  hamming_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_single(in_single), .in_double(in_double),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_status(out_status),
    .clear_counts(clear_counts),
    .ok_count(ok_count), .corr_count(corr_count), .uncorr_count(uncorr_count),
    .fifo_level(fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
    chk("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data",   32'(out_data),   32'(mq[0][5:2]));
      chk("out_status", 32'(out_status), 32'(mq[0][1:0]));
    end
    chk("ok_count",     32'(ok_count),     32'(mcnt[0]));
    chk("corr_count",   32'(corr_count),   32'(mcnt[1]));
    chk("uncorr_count", 32'(uncorr_count), 32'(mcnt[2]));
  endtask

  // One clock cycle: apply inputs, advance the model on the edge, check #1 later.
  task automatic step(input logic v, input logic [3:0] d, input logic s, input logic dbl,
                      input logic ordy, input logic clr, input logic rn, output logic pushed);
    bit do_push, do_pop;
    int cls;
    in_valid = v; in_data = d; in_single = s; in_double = dbl;
    out_ready = ordy; clear_counts = clr; rst_n = rn;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    cls     = dbl ? 2 : (s ? 1 : 0);
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      mcnt = '{0, 0, 0};
      pushed = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({d, 2'(cls)});
      if (clr) mcnt = '{0, 0, 0};
      else if (do_push && mcnt[cls] < CMAX) mcnt[cls]++;
      pushed = do_push;
    end
    #1;
    check_all();
    $display("cyc v=%0b d=%0h s=%0b dbl=%0b ordy=%0b clr=%0b rst_n=%0b -> lvl=%0d head=%0h/%0b cnt=%0d/%0d/%0d",
             v, d, s, dbl, ordy, clr, rn, fifo_level, out_data, out_status,
             ok_count, corr_count, uncorr_count);
  endtask

  initial begin
    logic p;
    logic [3:0] words[5];
    int idx;
    mcnt = '{0, 0, 0};

    // Reset, with explicit check that the head outputs are defined zeros.
    step(0, 0, 0, 0, 0, 0, 0, p);
    step(0, 0, 0, 0, 0, 0, 0, p);
    chk("rst_out_data",   32'(out_data),   32'h0);
    chk("rst_out_status", 32'(out_status), 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, p);

    // Single clean push then pop.
    step(1, 4'hA, 0, 0, 0, 0, 1, p);
    step(0, 0, 0, 0, 1, 0, 1, p);

    // Fill to full with in_valid held high; B waits for the first pop.
    words = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB};
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1, words[idx], 0, 0, 0, 0, 1, p);
      if (p) idx++;
    end
    chk("stall_accepted", 32'(idx), 32'd4);
    for (int c = 0; c < 20 && (idx < 5 || mq.size() != 0); c++) begin
      step(idx < 5, words[idx < 5 ? idx : 4], 0, 0, 1, 0, 1, p);
      if (p) idx++;
    end
    chk("drain_done", 32'(mq.size() == 0 && idx == 5), 32'd1);

    // Double dominates single; then a pure single error.
    step(1, 4'h6, 1, 1, 0, 0, 1, p);
    step(0, 0, 0, 0, 1, 0, 1, p);
    step(1, 4'h2, 1, 0, 0, 0, 1, p);
    step(0, 0, 0, 0, 1, 0, 1, p);

    // Saturation of the clean counter with push/pop streaming.
    for (int c = 0; c < 5; c++) step(1, 4'(c), 0, 0, 1, 0, 1, p);
    step(0, 0, 0, 0, 1, 0, 1, p);
    chk("ok_saturated", 32'(ok_count), 32'(CMAX));
    // Clear together with a single-error push: uncounted but stored.
    step(1, 4'hC, 1, 0, 0, 1, 1, p);

    // Level 2, then simultaneous push/pop for 6 cycles (pointer wrap).
    step(1, 4'hD, 0, 0, 0, 0, 1, p);
    for (int c = 0; c < 6; c++) step(1, 4'(c + 8), c[0], c == 3, 1, 0, 1, p);

    // Level 3 with non-zero counters, then a one-cycle reset pulse.
    step(1, 4'hE, 0, 1, 0, 0, 1, p);
    step(0, 0, 0, 0, 0, 0, 0, p);
    step(0, 0, 0, 0, 0, 0, 1, p);

    // Random traffic with occasional clears and resets.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 80) != 0, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
